ysyx_22041412_csr_ctrl: RTL and testbench

YSYX_22041412_CSR_CTRL -- requirements
Module: ysyx_22041412_csr_ctrl

---
 rtl/ysyx_22041412_csr_ctrl.sv | 145 ++++++++++++++
 tb/tb_ysyx_22041412_csr_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_csr_ctrl.sv
// SYSTEM-instruction sequencer: decodes CSR ops / ecall / mret, hands exactly one
// request to the CSR unit, then strobes a register writeback or a PC redirect.
module ysyx_22041412_csr_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [63:0] pc,
  input  logic [63:0] rs1_data,
  output logic        stall_o,
  output logic        csr_en,
  output logic [2:0]  csr_addr,
  output logic [2:0]  csr_func3,
  output logic [63:0] csr_pc,
  output logic [63:0] csr_wdata,
  input  logic        csr_ready,
  input  logic [63:0] csr_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        illegal_o,
  output logic        err_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;
  state_t r_state, w_next;

  logic [2:0]  r_addr, r_func3;
  logic [63:0] r_pc, r_wdata, r_rdata;
  logic [4:0]  r_rd;
  logic        r_ret, r_illegal;
  logic [3:0]  r_cnt;

  logic        w_sys, w_ecall, w_mret, w_mapped, w_legal, w_accept, w_illegal;
  logic [2:0]  w_f3, w_map, w_addr;
  logic [63:0] w_wdata;

  assign w_sys   = (inst[6:0] == 7'b1110011);
  assign w_f3    = inst[14:12];
  assign w_ecall = (inst == 32'h0000_0073);
  assign w_mret  = (inst == 32'h3020_0073);

  always_comb begin
    w_mapped = 1'b1;
    w_map    = 3'd0;
    case (inst[31:20])
      12'h300: w_map = 3'd2;
      12'h305: w_map = 3'd3;
      12'h341: w_map = 3'd4;
      12'h342: w_map = 3'd5;
      default: w_mapped = 1'b0;
    endcase
  end

  // func3=000 is only legal as the exact ecall/mret words; func3=100 is reserved
  assign w_legal   = w_sys && (w_ecall || w_mret ||
                     (w_f3 != 3'b000 && w_f3 != 3'b100 && w_mapped));
  assign w_addr    = w_ecall ? 3'd1 : (w_mret ? 3'd0 : w_map);
  assign w_wdata   = w_f3[2] ? {59'd0, inst[19:15]} : rs1_data;
  assign w_accept  = (r_state == S_IDLE) && inst_valid && w_legal;
  assign w_illegal = (r_state == S_IDLE) && inst_valid && w_sys && !w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    stall_o        = 1'b0;
    csr_en         = 1'b0;
    csr_addr       = 3'd0;
    csr_func3      = 3'd0;
    csr_pc         = 64'd0;
    csr_wdata      = 64'd0;
    wb_valid       = 1'b0;
    wb_rd          = 5'd0;
    wb_data        = 64'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    err_o          = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_accept;
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        stall_o   = 1'b1;
        csr_en    = 1'b1;
        csr_addr  = r_addr;
        csr_func3 = r_func3;
        csr_pc    = r_pc;
        csr_wdata = r_wdata;
        if (csr_ready)           w_next = S_DONE;
        else if (r_cnt == 4'hF)  w_next = S_ERR;
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (r_ret) begin
          redirect_valid = 1'b1;
          redirect_pc    = r_rdata;
        end else if (r_rd != 5'd0) begin
          wb_valid = 1'b1;
          wb_rd    = r_rd;
          wb_data  = r_rdata;
        end
      end
      default: begin
        stall_o = 1'b1;
        err_o   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= 3'd0;
      r_func3   <= 3'd0;
      r_pc      <= 64'd0;
      r_wdata   <= 64'd0;
      r_rdata   <= 64'd0;
      r_rd      <= 5'd0;
      r_ret     <= 1'b0;
      r_cnt     <= 4'd0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_illegal;
      if (w_accept) begin
        r_addr  <= w_addr;
        r_func3 <= w_f3;
        r_pc    <= pc;
        r_wdata <= w_wdata;
        r_rd    <= (w_ecall || w_mret) ? 5'd0 : inst[11:7];
        r_ret   <= w_ecall || w_mret;
        r_cnt   <= 4'd0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (r_state == S_REQ && csr_ready) r_rdata <= csr_rdata;
    end
  end

  assign illegal_o = r_illegal;
endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
// Scoreboard bench for the CSR sequencer: random SYSTEM / non-SYSTEM traffic, a
// small CSR-unit responder, timeout and reset-abandon scenarios.
module tb_ysyx_22041412_csr_ctrl;
  logic        clk = 0, rst_n = 0, inst_valid = 0, csr_ready = 0;
  logic [31:0] inst = 0;
  logic [63:0] pc = 0, rs1_data = 0, csr_rdata = 0;
  logic        stall_o, csr_en, wb_valid, redirect_valid, illegal_o, err_o;
  logic [2:0]  csr_addr, csr_func3;
  logic [63:0] csr_pc, csr_wdata, wb_data, redirect_pc;
  logic [4:0]  wb_rd;

  ysyx_22041412_csr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .rs1_data(rs1_data), .stall_o(stall_o), .csr_en(csr_en), .csr_addr(csr_addr),
    .csr_func3(csr_func3), .csr_pc(csr_pc), .csr_wdata(csr_wdata),
    .csr_ready(csr_ready), .csr_rdata(csr_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .illegal_o(illegal_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef enum int {EV_REQ, EV_WB, EV_RED, EV_ILL} kind_t;
  typedef struct {
    kind_t       kind;
    logic [2:0]  addr, func3;
    logic [63:0] pc, wdata, data;
    logic [4:0]  rd;
  } ev_t;
  typedef struct {
    bit          sys, legal, ret;
    logic [2:0]  addr, func3;
    logic [63:0] wdata;
    logic [4:0]  rd;
  } dec_t;

  ev_t q[$];
  int  n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the instruction-set rules
  function automatic dec_t model(input logic [31:0] i, input logic [63:0] rs1);
    dec_t d;
    int   idx;
    d.sys = (i[6:0] == 7'h73); d.legal = 0; d.ret = 0; d.addr = 0;
    d.func3 = i[14:12]; d.rd = i[11:7];
    d.wdata = i[14] ? 64'(i[19:15]) : rs1;
    case (i[31:20])
      12'h300: idx = 2;
      12'h305: idx = 3;
      12'h341: idx = 4;
      12'h342: idx = 5;
      default: idx = -1;
    endcase
    if (!d.sys) return d;
    if (i == 32'h0000_0073) begin d.legal = 1; d.ret = 1; d.addr = 1; d.rd = 0; end
    else if (i == 32'h3020_0073) begin d.legal = 1; d.ret = 1; d.addr = 0; d.rd = 0; end
    else if (d.func3 != 0 && d.func3 != 4 && idx >= 0) begin d.legal = 1; d.addr = idx[2:0]; end
    return d;
  endfunction

  function automatic bit outs_zero();
    return ({stall_o, csr_en, csr_addr, csr_func3, csr_pc, csr_wdata, wb_valid, wb_rd,
             wb_data, redirect_valid, redirect_pc, illegal_o, err_o} == '0);
  endfunction

  task automatic push(input kind_t k, input dec_t d, input logic [63:0] p, input logic [63:0] data);
    ev_t e;
    e.kind = k; e.addr = d.addr; e.func3 = d.func3; e.pc = p; e.wdata = d.wdata;
    e.rd = d.rd; e.data = data;
    q.push_back(e);
  endtask

  task automatic take(input kind_t k, input string nm, output ev_t e, output bit ok);
    ok = (q.size() != 0) && (q[0].kind == k);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: DUT presented event, expected queue holds %0d entries (head kind %0d)",
               nm, q.size(), q.size() != 0 ? int'(q[0].kind) : -1);
    end else e = q.pop_front();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or a result
  logic        prev_en = 0;
  logic [63:0] h_pc, h_wd;
  logic [5:0]  h_af;
  always @(negedge clk) begin : mon
    ev_t e;
    bit  ok;
    if (csr_en && !prev_en) begin
      take(EV_REQ, "unexpected_req", e, ok);
      if (ok) begin
        chk("req_addr", 64'(csr_addr), 64'(e.addr));
        chk("req_func3", 64'(csr_func3), 64'(e.func3));
        chk("req_pc", csr_pc, e.pc);
        chk("req_wdata", csr_wdata, e.wdata);
      end
      h_pc <= csr_pc; h_wd <= csr_wdata; h_af <= {csr_addr, csr_func3};
    end else if (csr_en) begin
      chk("req_stable_af", 64'({csr_addr, csr_func3}), 64'(h_af));
      chk("req_stable_pc", csr_pc, h_pc);
      chk("req_stable_wd", csr_wdata, h_wd);
    end
    prev_en <= csr_en;
    if (wb_valid) begin
      take(EV_WB, "unexpected_wb", e, ok);
      if (ok) begin
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_no_redirect", 64'(redirect_valid), 64'd0);
      end
    end else if (redirect_valid) begin
      take(EV_RED, "unexpected_redirect", e, ok);
      if (ok) chk("redirect_pc", redirect_pc, e.data);
    end
    if (illegal_o) take(EV_ILL, "unexpected_illegal", e, ok);
  end

  task automatic issue(input logic [31:0] i, input logic [63:0] p, input logic [63:0] r1,
                       input logic [63:0] rv, input int dly, input bit extra);
    dec_t d;
    d = model(i, r1);
    if (d.legal) begin
      push(EV_REQ, d, p, 64'd0);
      if (d.ret)            push(EV_RED, d, p, rv);
      else if (d.rd != 5'd0) push(EV_WB, d, p, rv);
    end else if (d.sys) push(EV_ILL, d, p, 64'd0);
    @(posedge clk); #1;
    inst_valid = 1; inst = i; pc = p; rs1_data = r1;
    @(negedge clk);
    chk("stall_on_present", 64'(stall_o), 64'(d.legal));
    @(posedge clk); #1;
    inst_valid = 0; inst = $urandom; pc = {$urandom, $urandom}; rs1_data = {$urandom, $urandom};
    @(negedge clk);
    if (!d.legal) begin
      chk("illegal_pulse", 64'(illegal_o), 64'(d.sys));
      chk("no_req_or_stall", 64'({csr_en, stall_o}), 64'd0);
      @(negedge clk);
      chk("illegal_one_cycle", 64'(illegal_o), 64'd0);
      return;
    end
    chk("csr_en_next_cycle", 64'(csr_en), 64'd1);
    repeat (dly) begin
      @(negedge clk);
      chk("stall_in_req", 64'({stall_o, csr_en}), 64'd3);
    end
    @(posedge clk); #1;
    csr_ready = 1; csr_rdata = rv;
    @(posedge clk); #1;
    csr_ready = extra; csr_rdata = {$urandom, $urandom};
    @(negedge clk);
    chk("done_csr_en_low", 64'(csr_en), 64'd0);
    chk("done_stall_low", 64'(stall_o), 64'd0);
    chk("done_wb_valid", 64'(wb_valid), 64'(!d.ret && d.rd != 5'd0));
    chk("done_redirect", 64'(redirect_valid), 64'(d.ret));
    @(posedge clk); #1;
    csr_ready = 0;
    @(negedge clk);
    chk("idle_after_done", 64'({wb_valid, redirect_valid, csr_en, stall_o, wb_data, redirect_pc}), 64'd0);
  endtask

  task automatic idle_ready();
    @(posedge clk); #1; csr_ready = 1; csr_rdata = {$urandom, $urandom};
    @(posedge clk); #1; csr_ready = 0;
    @(negedge clk);
    chk("ready_in_idle_ignored", 64'({csr_en, stall_o, wb_valid, redirect_valid}), 64'd0);
  endtask

  task automatic timeout_test();
    dec_t d;
    int   n;
    logic [31:0] i;
    i = {12'h342, 5'd4, 3'b011, 5'd3, 7'h73};
    d = model(i, 64'h55);
    push(EV_REQ, d, 64'h1000, 64'd0);
    @(posedge clk); #1; inst_valid = 1; inst = i; pc = 64'h1000; rs1_data = 64'h55;
    @(posedge clk); #1; inst_valid = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err_o) break;
      if (csr_en) n++;
    end
    chk("timeout_req_cycles", 64'(n), 64'd16);
    chk("err_state", 64'({err_o, stall_o, csr_en}), 64'b110);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'({err_o, stall_o, csr_en, wb_valid}), 64'b1100);
    #2 rst_n = 0;
    #1 chk("err_reset_outs_zero", 64'(outs_zero()), 64'd1);
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic reset_mid_req();
    dec_t d;
    int   bad;
    logic [31:0] i;
    i = {12'h341, 5'd2, 3'b001, 5'd7, 7'h73};
    d = model(i, 64'hABCD);
    push(EV_REQ, d, 64'h2000, 64'd0);
    @(posedge clk); #1; inst_valid = 1; inst = i; pc = 64'h2000; rs1_data = 64'hABCD;
    @(posedge clk); #1; inst_valid = 0;
    @(negedge clk);
    chk("rst_req_cycle1", 64'(csr_en), 64'd1);
    @(posedge clk); #2 rst_n = 0;
    #1 chk("mid_req_reset_outs_zero", 64'(outs_zero()), 64'd1);
    @(posedge clk); #1; rst_n = 1; csr_ready = 1; csr_rdata = 64'hDEAD;
    @(posedge clk); #1; csr_ready = 0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb_valid || redirect_valid || csr_en || stall_o) bad++;
    end
    chk("no_result_after_reset", 64'(bad), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ri, rr;
    logic [11:0] cs;
    int k;
    repeat (2) @(negedge clk);
    chk("reset_outs_zero", 64'(outs_zero()), 64'd1);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("idle_outs_zero", 64'(outs_zero()), 64'd1);

    issue({12'h305, 5'd1, 3'b001, 5'd5, 7'h73}, 64'h8000_0000, 64'h8000_0100, 64'h0, 0, 0);
    issue(32'h0000_0073, 64'h8000_0040, 64'h0, 64'h8000_0100, 0, 0);
    issue({12'h300, 5'd3, 3'b110, 5'd0, 7'h73}, 64'h8000_0044, 64'hFFFF, 64'h1888, 1, 0);
    issue({12'h7C0, 5'd1, 3'b001, 5'd2, 7'h73}, 64'h8000_0048, 64'h1, 64'h0, 0, 0);
    issue(32'h3020_0073, 64'h8000_004C, 64'h0, 64'h8000_0200, 2, 1);
    issue(32'h0010_0073, 64'h8000_0050, 64'h0, 64'h0, 0, 0);
    issue({12'h342, 5'd9, 3'b100, 5'd4, 7'h73}, 64'h8000_0054, 64'h0, 64'h0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 9);
      rr = $urandom;
      case (k)
        0: ri = 32'h0000_0073;
        1: ri = 32'h3020_0073;
        2: ri = 32'h0010_0073;
        3: begin ri = rr; if (ri[6:0] == 7'h73) ri[0] = 1'b0; end
        4: ri = {rr[31:20], rr[19:15], rr[14] ? 3'b100 : 3'b000, rr[11:7], 7'h73};
        default: begin
          case ($urandom_range(0, 4))
            0: cs = 12'h300;
            1: cs = 12'h305;
            2: cs = 12'h341;
            3: cs = 12'h342;
            default: cs = rr[31:20];
          endcase
          ri = {cs, rr[19:15], 3'($urandom_range(1, 7)), ($urandom_range(0, 5) == 0) ? 5'd0 : rr[11:7], 7'h73};
        end
      endcase
      issue(ri, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle_ready();
    end

    timeout_test();
    reset_mid_req();
    issue({12'h305, 5'd1, 3'b010, 5'd6, 7'h73}, 64'h3000, 64'h77, 64'h1234, 0, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
